// File: rtl/nand_pkg.sv
// Shared definitions for the NAND flash responder: command opcodes, page size,
// FSM state encoding and the debug view exported by the top level.
package nand_pkg;

  localparam logic [7:0] CMD_READ0    = 8'h00;
  localparam logic [7:0] CMD_READ1    = 8'h01;
  localparam logic [7:0] CMD_PROG     = 8'h80;
  localparam logic [7:0] CMD_PROG_CFM = 8'h10;
  localparam logic [7:0] CMD_RESET    = 8'hFF;

  localparam int PAGE_BYTES = 512;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD_BUSY,
    ST_DATA_OUT,
    ST_DATA_IN,
    ST_PROG_BUSY,
    ST_RST_BUSY
  } nand_state_e;

  typedef enum logic {
    OP_READ,
    OP_PROG
  } nand_op_e;

  typedef struct packed {
    nand_state_e state;
    logic        io_oe;
    logic        half;
  } nand_dbg_t;

endpackage

// File: rtl/nand_edge_sync.sv
// Registers the flash write/read strobes and emits one-clock rising-edge pulses.
// Strobes idle high, so the history flops reset to 1 to avoid a false edge.
module nand_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wen,
  input  logic i_ren,
  output logic o_wen_rise,
  output logic o_ren_rise
);

  logic r_wen_q;
  logic r_ren_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen_q <= 1'b1;
      r_ren_q <= 1'b1;
    end else begin
      r_wen_q <= i_wen;
      r_ren_q <= i_ren;
    end
  end

  assign o_wen_rise = ~r_wen_q & i_wen;
  assign o_ren_rise = ~r_ren_q & i_ren;

endmodule

// File: rtl/nand_flash_responder.sv
// NAND flash target model: decodes CLE/ALE command and address cycles, serves page
// reads, accepts page programs and drives ready/busy. NAND_PROG_AND_EN selects
// AND-style programming (bits only clear, array erased to 0xFF).
//
// Valid/ready contract with the controller: a bus cycle is taken on each WEN rising
// edge (CLE/ALE/IO sampled together) and each REN rising edge advances the read
// column; F_RB low means every such edge is ignored until F_RB returns high.
module nand_flash_responder
  import nand_pkg::*;
#(
  parameter int ROW_W  = 9,
  parameter int T_R    = 20,
  parameter int T_PROG = 40,
  parameter int T_RST  = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  inout  wire [7:0] F_IO,
  input  logic      F_CLE,
  input  logic      F_ALE,
  input  logic      F_WEN,
  input  logic      F_REN,
  output logic      F_RB,
  output nand_dbg_t o_dbg
);

  localparam int NUM_PAGES = 2 ** ROW_W;
  localparam int COL_W     = $clog2(PAGE_BYTES);
  localparam int ADDR_W    = ROW_W + COL_W;

  nand_state_e      r_state;
  nand_op_e         r_op;
  logic             r_rd_arm;
  logic [1:0]       r_addr_cnt;
  logic [7:0]       r_col_lo;
  logic [7:0]       r_row_lo;
  logic [ROW_W-1:0] r_row;
  logic [COL_W:0]   r_col;
  logic             r_half;
  logic [15:0]      r_busy_cnt;
  logic             r_rb;

  logic [7:0] r_mem [NUM_PAGES*PAGE_BYTES];

  logic              w_wen_rise;
  logic              w_ren_rise;
  logic [ADDR_W-1:0] w_addr;
  logic              w_mem_we;
  logic              w_io_oe;
  logic [7:0]        w_rd_data;

  nand_edge_sync u_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wen      (F_WEN),
    .i_ren      (F_REN),
    .o_wen_rise (w_wen_rise),
    .o_ren_rise (w_ren_rise)
  );

  assign w_addr   = {r_row, r_col[COL_W-1:0]};
  assign w_mem_we = w_wen_rise && (r_state == ST_DATA_IN) && !F_CLE && !F_ALE && !r_col[COL_W];

  // In AND mode the array holds inverted bytes so zero-initialised storage reads as erased 0xFF.
`ifdef NAND_PROG_AND_EN
  assign w_rd_data = r_col[COL_W] ? 8'hFF : ~r_mem[w_addr];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_addr] <= r_mem[w_addr] | ~F_IO;
    end
  end
`else
  assign w_rd_data = r_col[COL_W] ? 8'hFF : r_mem[w_addr];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_addr] <= F_IO;
    end
  end
`endif

  assign w_io_oe = (r_state == ST_DATA_OUT) && !F_REN && !F_CLE && !F_ALE;
  assign F_IO    = w_io_oe ? w_rd_data : 8'hzz;
  assign F_RB    = r_rb;
  assign o_dbg   = '{state: r_state, io_oe: w_io_oe, half: r_half};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_op       <= OP_READ;
      r_rd_arm   <= 1'b0;
      r_addr_cnt <= 2'd0;
      r_col_lo   <= 8'd0;
      r_row_lo   <= 8'd0;
      r_row      <= '0;
      r_col      <= '0;
      r_half     <= 1'b0;
      r_busy_cnt <= 16'd0;
      r_rb       <= 1'b1;
    end else begin
      case (r_state)
        ST_RD_BUSY, ST_PROG_BUSY, ST_RST_BUSY: begin
          if (r_busy_cnt == 16'd0) begin
            r_rb <= 1'b1;
            if (r_state == ST_RD_BUSY) begin
              r_state <= ST_DATA_OUT;
              r_half  <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_busy_cnt <= r_busy_cnt - 16'd1;
          end
        end
        default: begin
          // A WEN event takes priority; a coincident REN edge is dropped.
          if (w_wen_rise) begin
            if (F_CLE && !F_ALE && F_IO == CMD_RESET) begin
              r_state    <= ST_RST_BUSY;
              r_half     <= 1'b0;
              r_rd_arm   <= 1'b0;
              r_rb       <= 1'b0;
              r_busy_cnt <= 16'(T_RST - 1);
            end else if (r_state == ST_ADDR) begin
              if (F_CLE) begin
                r_state  <= ST_IDLE;
                r_rd_arm <= 1'b0;
              end else if (F_ALE) begin
                case (r_addr_cnt)
                  2'd0: begin
                    r_col_lo   <= F_IO;
                    r_addr_cnt <= 2'd1;
                  end
                  2'd1: begin
                    r_row_lo   <= F_IO;
                    r_addr_cnt <= 2'd2;
                  end
                  default: begin
                    r_row      <= ROW_W'({F_IO, r_row_lo});
                    r_col      <= {1'b0, r_half, r_col_lo};
                    r_addr_cnt <= 2'd0;
                    if (r_op == OP_READ) begin
                      r_state    <= ST_RD_BUSY;
                      r_rb       <= 1'b0;
                      r_busy_cnt <= 16'(T_R - 1);
                    end else begin
                      r_state <= ST_DATA_IN;
                    end
                  end
                endcase
              end
            end else if (F_CLE && !F_ALE) begin
              case (F_IO)
                CMD_READ0, CMD_READ1: begin
                  r_half   <= (F_IO == CMD_READ1);
                  r_state  <= ST_IDLE;
                  r_rd_arm <= 1'b1;
                end
                CMD_PROG: begin
                  r_op       <= OP_PROG;
                  r_addr_cnt <= 2'd0;
                  r_state    <= ST_ADDR;
                  r_rd_arm   <= 1'b0;
                end
                CMD_PROG_CFM: begin
                  if (r_state == ST_DATA_IN) begin
                    r_state    <= ST_PROG_BUSY;
                    r_half     <= 1'b0;
                    r_rd_arm   <= 1'b0;
                    r_rb       <= 1'b0;
                    r_busy_cnt <= 16'(T_PROG - 1);
                  end
                end
                default: ;
              endcase
            end else if (F_ALE && !F_CLE && r_state == ST_IDLE && r_rd_arm) begin
              // First read address byte arrives straight from IDLE after 0x00/0x01.
              r_col_lo   <= F_IO;
              r_addr_cnt <= 2'd1;
              r_op       <= OP_READ;
              r_state    <= ST_ADDR;
              r_rd_arm   <= 1'b0;
            end else if (!F_CLE && !F_ALE && r_state == ST_DATA_IN && !r_col[COL_W]) begin
              r_col <= r_col + 1'b1;
            end
          end else if (w_ren_rise && r_state == ST_DATA_OUT && !r_col[COL_W]) begin
            r_col <= r_col + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nand_flash_responder.sv
// Directed bench for nand_flash_responder: reset, program/read round trips,
// half-page addressing, end-of-page saturation, ignored strobes and mid-op resets.
`timescale 1ns/1ps
module tb_nand_flash_responder;
  import nand_pkg::*;

  localparam int T_R    = 20;
  localparam int T_PROG = 40;
  localparam int T_RST  = 5;

  logic      clk    = 1'b0;
  logic      rst_n  = 1'b0;
  logic      f_cle  = 1'b0;
  logic      f_ale  = 1'b0;
  logic      f_wen  = 1'b1;
  logic      f_ren  = 1'b1;
  logic [7:0] io_drv = 8'h00;
  logic      io_oe  = 1'b0;
  wire [7:0] f_io;
  wire       f_rb;
  nand_dbg_t dbg;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] wr_q[$];

  assign f_io = io_oe ? io_drv : 8'hzz;

  nand_flash_responder #(
    .ROW_W  (9),
    .T_R    (T_R),
    .T_PROG (T_PROG),
    .T_RST  (T_RST)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .F_IO  (f_io),
    .F_CLE (f_cle),
    .F_ALE (f_ale),
    .F_WEN (f_wen),
    .F_REN (f_ren),
    .F_RB  (f_rb),
    .o_dbg (dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    if (obs !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One WEN-latched bus cycle; returns on the falling edge after the latch.
  task automatic send(input logic cle, input logic ale, input logic [7:0] d);
    @(negedge clk);
    f_cle = cle; f_ale = ale; io_drv = d; io_oe = 1'b1; f_wen = 1'b0;
    @(negedge clk);
    f_wen = 1'b1;
    @(negedge clk);
    f_cle = 1'b0; f_ale = 1'b0; io_oe = 1'b0;
  endtask

  task automatic addr3(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2);
    send(1'b0, 1'b1, a0);
    send(1'b0, 1'b1, a1);
    send(1'b0, 1'b1, a2);
  endtask

  task automatic wait_busy(input int exp_len, input string tag);
    int n;
    n = 0;
    while (f_rb == 1'b0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    check(tag, 32'(n), 32'(exp_len));
  endtask

  task automatic read_byte(output logic [7:0] d);
    @(negedge clk);
    f_ren = 1'b0;
    @(negedge clk);
    d = f_io;
    @(negedge clk);
    f_ren = 1'b1;
    @(negedge clk);
  endtask

  task automatic program_page(input logic hi, input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2);
    if (hi) send(1'b1, 1'b0, CMD_READ1);
    send(1'b1, 1'b0, CMD_PROG);
    addr3(a0, a1, a2);
    foreach (wr_q[i]) send(1'b0, 1'b0, wr_q[i]);
    send(1'b1, 1'b0, CMD_PROG_CFM);
    wait_busy(T_PROG, "prog_busy_len");
    wr_q.delete();
  endtask

  task automatic read_check(input logic hi, input logic [7:0] a0, input logic [7:0] a1,
                            input logic [7:0] a2, input string tag);
    logic [7:0] d;
    send(1'b1, 1'b0, hi ? CMD_READ1 : CMD_READ0);
    addr3(a0, a1, a2);
    wait_busy(T_R, "rd_busy_len");
    while (exp_q.size() > 0) begin
      read_byte(d);
      check(tag, 32'(d), 32'(exp_q.pop_front()));
    end
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rb", 32'(f_rb), 32'd1);
    check("rst_io_released", 32'(dbg.io_oe), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(ST_IDLE));
    rst_n = 1'b1;

    // Reset command busy time
    send(1'b1, 1'b0, CMD_RESET);
    wait_busy(T_RST, "rst_busy_len");
    check("rst_cmd_state", 32'(dbg.state), 32'(ST_IDLE));

    // Program 16 bytes at page 5 col 0x010 and read them back
    for (int i = 0; i < 16; i++) wr_q.push_back(8'(i));
    program_page(1'b0, 8'h10, 8'h05, 8'h00);
    for (int i = 0; i < 16; i++) exp_q.push_back(8'(i));
    read_check(1'b0, 8'h10, 8'h05, 8'h00, "p5_rd");

    // Bus drive gating while in DATA_OUT
    check("dout_ren_high_oe", 32'(dbg.io_oe), 32'd0);
    @(negedge clk); f_ren = 1'b0;
    #1 check("dout_ren_low_oe", 32'(dbg.io_oe), 32'd1);
    f_cle = 1'b1;
    #1 check("dout_cle_oe", 32'(dbg.io_oe), 32'd0);
    f_cle = 1'b0;
    @(negedge clk); f_ren = 1'b1;

    // Second half of page 511
    wr_q.push_back(8'hA5);
    program_page(1'b1, 8'h00, 8'hFF, 8'h01);
    exp_q.push_back(8'hA5);
    read_check(1'b1, 8'h00, 8'hFF, 8'h01, "p511_hi");
    // No 0x00 here: this program lands at byte 0 only if DATA_OUT entry cleared half
    wr_q.push_back(8'h66);
    program_page(1'b0, 8'h00, 8'hFF, 8'h01);
    exp_q.push_back(8'h66);
    read_check(1'b0, 8'h00, 8'hFF, 8'h01, "p511_lo_half_clr");
    exp_q.push_back(8'hA5);
    read_check(1'b1, 8'h00, 8'hFF, 8'h01, "p511_hi_kept");

    // End of page: 0x1FE/0x1FF hold data, a third write is discarded, reads saturate to 0xFF
    wr_q.push_back(8'h11); wr_q.push_back(8'h22); wr_q.push_back(8'h33);
    program_page(1'b1, 8'hFE, 8'h02, 8'h00);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    read_check(1'b1, 8'hFE, 8'h02, 8'h00, "eop");

    // Double program of one byte
    wr_q.push_back(8'hF0);
    program_page(1'b0, 8'h03, 8'h07, 8'h00);
    wr_q.push_back(8'h3C);
    program_page(1'b0, 8'h03, 8'h07, 8'h00);
`ifdef NAND_PROG_AND_EN
    exp_q.push_back(8'h30);
`else
    exp_q.push_back(8'h3C);
`endif
    read_check(1'b0, 8'h03, 8'h07, 8'h00, "reprogram");

    // WEN pulses during PROG_BUSY are ignored
    send(1'b1, 1'b0, CMD_PROG);
    addr3(8'h20, 8'h08, 8'h00);
    send(1'b0, 1'b0, 8'h77);
    send(1'b1, 1'b0, CMD_PROG_CFM);
    fork
      wait_busy(T_PROG, "prog_busy_ignore_len");
      begin
        send(1'b1, 1'b0, CMD_RESET);
        send(1'b0, 1'b1, 8'h00);
        send(1'b1, 1'b0, CMD_READ0);
      end
    join
    check("prog_busy_ignore_state", 32'(dbg.state), 32'(ST_IDLE));
    exp_q.push_back(8'h77);
    read_check(1'b0, 8'h20, 8'h08, 8'h00, "ignore_rd");

    // rst_n during RD_BUSY releases F_RB asynchronously
    send(1'b1, 1'b0, CMD_READ0);
    addr3(8'h20, 8'h08, 8'h00);
    repeat (5) @(negedge clk);
    check("rd_busy_mid_rb", 32'(f_rb), 32'd0);
    rst_n = 1'b0;
    #1 check("async_rst_rb", 32'(f_rb), 32'd1);
    check("async_rst_state", 32'(dbg.state), 32'(ST_IDLE));
    @(negedge clk); rst_n = 1'b1;
    exp_q.push_back(8'h77);
    read_check(1'b0, 8'h20, 8'h08, 8'h00, "after_rst_rd");

    // rst_n during DATA_IN keeps bytes already written
    send(1'b1, 1'b0, CMD_PROG);
    addr3(8'h40, 8'h09, 8'h00);
    send(1'b0, 1'b0, 8'hC3);
    send(1'b0, 1'b0, 8'hC4);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    check("din_rst_state", 32'(dbg.state), 32'(ST_IDLE));
    exp_q.push_back(8'hC3); exp_q.push_back(8'hC4);
    read_check(1'b0, 8'h40, 8'h09, 8'h00, "din_rst_keep");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
